play_mode_ctrl: RTL and testbench
=================================

Name: play_mode_ctrl

Overview:
- Top-level mode sequencer and output arbiter for the piano/buzzer datapath.
- Three note sources compete for the single buzzer/LED output: free play, auto play and learn mode. Each source presents note, octave and LED values.
- Debounces the mode and pause buttons, runs the mode state machine, and enables and restarts the selected source.
- Inserts a muted gap on every mode switch, then muxes the active source onto the buzzer/LED outputs.

Parameters:
- DEBOUNCE, 200000: cycles a synchronized button level must stay stable before it is accepted.
- GAP, 1000000: muted cycles inserted between modes on every switch.
- NOTE_END, 4'hF: library end-of-song marker. Mapped to rest at the output.

Ports:
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-low
- btn_next  in  1  raw mode-next button
- btn_prev  in  1  raw mode-previous button
- btn_pause  in  1  raw pause toggle button
- free_note / auto_note / learn_note  in  4 each  source note codes (0 = rest)
- free_oct / auto_oct / learn_oct  in  2 each  source octaves
- free_led / auto_led / learn_led  in  7 each  source LED patterns
- note_out  out  4  note to buzzer driver
- octave_out  out  2  octave to buzzer driver
- led_out  out  7  LED pattern
- mode_out  out  2  mode code: 00 free, 01 auto, 10 learn
- src_en  out  3  one-hot source enable: bit0 free, bit1 auto, bit2 learn
- src_restart  out  3  one-cycle restart pulse per source
- paused  out  1  high while in PAUSE

Behaviour:
- Reset values (asynchronous): state FREE, target FREE, mode_out 00, src_en 001, src_restart 000, note_out 0, octave_out 0, led_out 0, paused 0. All counters and synchronizers are cleared.
- Button conditioning, per button:
  - 2-flop synchronizer, then a debounce counter.
  - The debounced level changes only after the synchronized level has differed from it for DEBOUNCE consecutive cycles; any bounce resets the count.
  - A rising edge of the debounced level produces a 1-cycle event. Press-to-event latency is DEBOUNCE+3 cycles.
- Event rules:
  - next and prev events in the same cycle cancel each other: no action.
  - A mode event together with a pause event in the same cycle: the mode event wins and the pause event is dropped.
- Mode order: FREE -> AUTO -> LEARN -> FREE on next. prev follows the reverse order. Both wrap around.
- States: FREE, AUTO, LEARN, MUTE, PAUSE.
- Active states (FREE/AUTO/LEARN):
  - src_en is one-hot for that mode.
  - Outputs register the selected source's inputs, giving 1-cycle latency.
  - A source note equal to NOTE_END is output as note 0 with led_out 0.
- Mode event in an active state or in PAUSE:
  - target <= next/prev of the current mode; mode_out <= target on the same edge.
  - Enter MUTE; the gap counter loads 0.
- MUTE:
  - src_en = 000, note_out = 0, led_out = 0; octave_out holds its value.
  - Counts GAP cycles.
  - A further mode event retargets relative to the current target and reloads the counter to 0. mode_out follows.
  - Pause events are ignored.
  - On terminal count: src_restart[target] pulses for exactly 1 cycle, src_en becomes the target one-hot on the same edge, and the state becomes the target.
- Pause event in AUTO or LEARN:
  - Enter PAUSE, paused = 1, src_en = 000 so the source freezes its position, note_out = 0, led_out = 0.
  - No restart pulse.
- Pause event in PAUSE: return to the paused-from mode with the same enable and no restart. This takes 1 cycle.
- Pause event in FREE: ignored.
- A mode event in PAUSE clears paused and follows the MUTE path from the paused-from mode.
- Reset mid-gap or mid-pause returns to the reset values immediately, with no restart pulse.

Decomposition:
- Shared package (music_pkg): mode codes MODE_FREE/MODE_AUTO/MODE_LEARN, NOTE_REST = 4'h0, NOTE_END = 4'hF, LED_OFF = 7'b0. The package is used by this block, the auto player and the learn module.
- Sub-module btn_cond (synchronizer + debounce + rise-edge pulse, parameter DEBOUNCE), instantiated three times.
- The FSM and output mux stay in play_mode_ctrl.

Test Plan (DEBOUNCE=4, GAP=8):
- Reset release, free_note=3, free_oct=2, free_led=0000100 -> 1 cycle later note_out=3, octave_out=2, led_out=0000100, src_en=001, mode_out=00.
- btn_next held 10 cycles -> event at cycle 7; mode_out=01 and note_out=0 for 8 cycles; then src_restart=010 for 1 cycle, src_en=010, note_out tracks auto_note.
- btn_next glitches of 1-3 cycles repeated -> no event, mode_out stays 00. From FREE, press btn_prev -> mode_out=10 (wrap).
- In AUTO press pause -> paused=1, src_en=000, note_out=0. Press pause again -> src_en=010, no src_restart pulse. auto_note=4'hF -> note_out=0, led_out=0.
- In MUTE (target AUTO) at gap cycle 5 press next -> target LEARN, gap restarts; 8 muted cycles later src_restart=100. Asserting reset mid-gap -> all outputs at reset values immediately.
- btn_next and btn_prev debounced edges in the same cycle -> no state change. A mode event coincident with a pause event in AUTO -> MUTE entered, paused stays 0.

Source files
------------

// File: rtl/music_pkg.sv
// Shared mode codes, note markers and mode helpers for the piano/buzzer datapath.
// Used by the mode controller, the auto player and the learn module.
package music_pkg;

  typedef enum logic [1:0] {
    MODE_FREE  = 2'b00,
    MODE_AUTO  = 2'b01,
    MODE_LEARN = 2'b10
  } mode_t;

  localparam logic [3:0] NOTE_REST = 4'h0;
  localparam logic [3:0] NOTE_END  = 4'hF;
  localparam logic [6:0] LED_OFF   = 7'b0;

  // Mode ring FREE -> AUTO -> LEARN -> FREE; fwd=0 walks it backwards.
  function automatic mode_t mode_step(input mode_t m, input logic fwd);
    case (m)
      MODE_FREE: return fwd ? MODE_AUTO  : MODE_LEARN;
      MODE_AUTO: return fwd ? MODE_LEARN : MODE_FREE;
      default:   return fwd ? MODE_FREE  : MODE_AUTO;
    endcase
  endfunction

  function automatic logic [2:0] mode_onehot(input mode_t m);
    return 3'b001 << m;
  endfunction

endpackage

// File: rtl/btn_cond.sv
// Button conditioner: 2-flop synchronizer, stability debounce and a
// registered one-cycle pulse on each accepted press.
module btn_cond #(
  parameter int DEBOUNCE = 200000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic evt
);

  localparam int CW = $clog2(DEBOUNCE + 1);

  logic          sync1, sync2;
  logic          level, level_d;
  logic [CW-1:0] cnt;

  // The level flips only after DEBOUNCE consecutive disagreeing samples.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      evt     <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= btn;
      sync2   <= sync1;
      level_d <= level;
      evt     <= level & ~level_d;
      if (sync2 != level) begin
        if (cnt == CW'(DEBOUNCE - 1)) begin
          level <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/play_mode_ctrl.sv
// Mode sequencer and output arbiter: picks one of three note sources,
// inserts a muted gap on every mode switch and handles pause.
module play_mode_ctrl
  import music_pkg::*;
#(
  parameter int         DEBOUNCE = 200000,
  parameter int         GAP      = 1000000,
  parameter logic [3:0] NOTE_END = 4'hF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_next,
  input  logic       btn_prev,
  input  logic       btn_pause,
  input  logic [3:0] free_note,
  input  logic [3:0] auto_note,
  input  logic [3:0] learn_note,
  input  logic [1:0] free_oct,
  input  logic [1:0] auto_oct,
  input  logic [1:0] learn_oct,
  input  logic [6:0] free_led,
  input  logic [6:0] auto_led,
  input  logic [6:0] learn_led,
  output logic [3:0] note_out,
  output logic [1:0] octave_out,
  output logic [6:0] led_out,
  output logic [1:0] mode_out,
  output logic [2:0] src_en,
  output logic [2:0] src_restart,
  output logic       paused
);

  localparam int GW = $clog2(GAP + 1);

  typedef enum logic [2:0] {
    ST_FREE, ST_AUTO, ST_LEARN, ST_MUTE, ST_PAUSE
  } state_t;

  function automatic state_t mode_state(input mode_t m);
    case (m)
      MODE_AUTO:  return ST_AUTO;
      MODE_LEARN: return ST_LEARN;
      default:    return ST_FREE;
    endcase
  endfunction

  logic next_evt, prev_evt, pause_evt, mode_evt;

  btn_cond #(.DEBOUNCE(DEBOUNCE)) u_next  (.clk(clk), .reset(reset), .btn(btn_next),  .evt(next_evt));
  btn_cond #(.DEBOUNCE(DEBOUNCE)) u_prev  (.clk(clk), .reset(reset), .btn(btn_prev),  .evt(prev_evt));
  btn_cond #(.DEBOUNCE(DEBOUNCE)) u_pause (.clk(clk), .reset(reset), .btn(btn_pause), .evt(pause_evt));

  assign mode_evt = next_evt ^ prev_evt;

  state_t        state, state_n;
  mode_t         target, target_n, step_mode;
  logic [GW-1:0] gap, gap_n;
  logic [3:0]    note_n, sel_note;
  logic [1:0]    oct_n, sel_oct, mode_n;
  logic [6:0]    led_n, sel_led;
  logic [2:0]    en_n, restart_n;
  logic          paused_n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_FREE;
      target      <= MODE_FREE;
      gap         <= '0;
      note_out    <= NOTE_REST;
      octave_out  <= 2'b00;
      led_out     <= LED_OFF;
      mode_out    <= MODE_FREE;
      src_en      <= 3'b001;
      src_restart <= 3'b000;
      paused      <= 1'b0;
    end else begin
      state       <= state_n;
      target      <= target_n;
      gap         <= gap_n;
      note_out    <= note_n;
      octave_out  <= oct_n;
      led_out     <= led_n;
      mode_out    <= mode_n;
      src_en      <= en_n;
      src_restart <= restart_n;
      paused      <= paused_n;
    end
  end

  always_comb begin
    sel_note = free_note;
    sel_oct  = free_oct;
    sel_led  = free_led;
    case (target)
      MODE_AUTO:  begin sel_note = auto_note;  sel_oct = auto_oct;  sel_led = auto_led;  end
      MODE_LEARN: begin sel_note = learn_note; sel_oct = learn_oct; sel_led = learn_led; end
      default: ;
    endcase
  end

  // Target always equals the current mode outside MUTE, so every mode
  // event steps relative to it, whether active, paused or mid-gap.
  always_comb begin
    state_n   = state;
    target_n  = target;
    gap_n     = gap;
    note_n    = note_out;
    oct_n     = octave_out;
    led_n     = led_out;
    mode_n    = mode_out;
    en_n      = src_en;
    restart_n = 3'b000;
    paused_n  = paused;
    step_mode = mode_step(target, next_evt);

    case (state)
      ST_MUTE: begin
        note_n = NOTE_REST;
        led_n  = LED_OFF;
        en_n   = 3'b000;
        if (mode_evt) begin
          target_n = step_mode;
          mode_n   = step_mode;
          gap_n    = '0;
        end else if (gap == GW'(GAP - 1)) begin
          restart_n = mode_onehot(target);
          en_n      = mode_onehot(target);
          state_n   = mode_state(target);
          gap_n     = '0;
        end else begin
          gap_n = gap + GW'(1);
        end
      end
      default: begin
        if (mode_evt) begin
          target_n = step_mode;
          mode_n   = step_mode;
          state_n  = ST_MUTE;
          gap_n    = '0;
          en_n     = 3'b000;
          note_n   = NOTE_REST;
          led_n    = LED_OFF;
          paused_n = 1'b0;
        end else if (state == ST_PAUSE) begin
          note_n = NOTE_REST;
          led_n  = LED_OFF;
          if (pause_evt) begin
            state_n  = mode_state(target);
            en_n     = mode_onehot(target);
            paused_n = 1'b0;
          end
        end else if (pause_evt && state != ST_FREE) begin
          state_n  = ST_PAUSE;
          paused_n = 1'b1;
          en_n     = 3'b000;
          note_n   = NOTE_REST;
          led_n    = LED_OFF;
        end else begin
          note_n = (sel_note == NOTE_END) ? NOTE_REST : sel_note;
          led_n  = (sel_note == NOTE_END) ? LED_OFF : sel_led;
          oct_n  = sel_oct;
          en_n   = mode_onehot(target);
        end
      end
    endcase
  end

endmodule

// File: tb/tb_play_mode_ctrl.sv
// Directed bench for play_mode_ctrl with DEBOUNCE=4 and GAP=8; a press
// shows its effect at the 8th clock edge after the button goes high.
module tb_play_mode_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_next, btn_prev, btn_pause;
  logic [3:0] free_note, auto_note, learn_note;
  logic [1:0] free_oct, auto_oct, learn_oct;
  logic [6:0] free_led, auto_led, learn_led;
  logic [3:0] note_out;
  logic [1:0] octave_out;
  logic [6:0] led_out;
  logic [1:0] mode_out;
  logic [2:0] src_en, src_restart;
  logic       paused;

  int passed = 0;
  int total  = 0;

  play_mode_ctrl #(.DEBOUNCE(4), .GAP(8)) dut (
    .clk(clk), .reset(reset),
    .btn_next(btn_next), .btn_prev(btn_prev), .btn_pause(btn_pause),
    .free_note(free_note), .auto_note(auto_note), .learn_note(learn_note),
    .free_oct(free_oct), .auto_oct(auto_oct), .learn_oct(learn_oct),
    .free_led(free_led), .auto_led(auto_led), .learn_led(learn_led),
    .note_out(note_out), .octave_out(octave_out), .led_out(led_out),
    .mode_out(mode_out), .src_en(src_en), .src_restart(src_restart),
    .paused(paused)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  initial begin
    reset = 1'b0;
    btn_next = 1'b0; btn_prev = 1'b0; btn_pause = 1'b0;
    free_note  = 4'd3; free_oct  = 2'd2; free_led  = 7'b0000100;
    auto_note  = 4'd5; auto_oct  = 2'd1; auto_led  = 7'b0100000;
    learn_note = 4'd9; learn_oct = 2'd3; learn_led = 7'b1000001;
    tick(2);
    check_output("rst_note", note_out, 0);
    check_output("rst_oct", octave_out, 0);
    check_output("rst_led", led_out, 0);
    check_output("rst_mode", mode_out, 0);
    check_output("rst_en", src_en, 3'b001);
    check_output("rst_restart", src_restart, 0);
    check_output("rst_paused", paused, 0);

    reset = 1'b1;
    tick(1);
    check_output("free_note", note_out, 3);
    check_output("free_oct", octave_out, 2);
    check_output("free_led", led_out, 7'b0000100);

    // pause has no effect in FREE
    btn_pause = 1'b1;
    tick(8);
    check_output("free_pause_paused", paused, 0);
    check_output("free_pause_en", src_en, 3'b001);
    check_output("free_pause_note", note_out, 3);
    btn_pause = 1'b0;
    tick(10);

    for (int g = 1; g <= 3; g++) begin
      btn_next = 1'b1;
      tick(g);
      btn_next = 1'b0;
      tick(4);
    end
    tick(6);
    check_output("glitch_mode", mode_out, 0);
    check_output("glitch_en", src_en, 3'b001);

    // prev from FREE wraps to LEARN
    btn_prev = 1'b1;
    tick(7);
    check_output("prev_latency_mode", mode_out, 0);
    tick(1);
    check_output("prev_wrap_mode", mode_out, 2'b10);
    check_output("mute_en", src_en, 0);
    check_output("mute_note", note_out, 0);
    btn_prev = 1'b0;
    tick(7);
    check_output("mute_end_early", src_restart, 0);
    tick(1);
    check_output("learn_restart", src_restart, 3'b100);
    check_output("learn_en", src_en, 3'b100);
    tick(1);
    check_output("learn_restart_gone", src_restart, 0);
    check_output("learn_note", note_out, 9);
    check_output("learn_led", led_out, 7'b1000001);
    check_output("learn_oct", octave_out, 3);

    btn_prev = 1'b1;
    tick(8);
    check_output("to_auto_mode", mode_out, 2'b01);
    btn_prev = 1'b0;
    tick(8);
    check_output("auto_restart", src_restart, 3'b010);
    check_output("auto_en", src_en, 3'b010);
    tick(1);
    check_output("auto_note", note_out, 5);
    check_output("auto_led", led_out, 7'b0100000);

    btn_pause = 1'b1;
    tick(8);
    check_output("pause_paused", paused, 1);
    check_output("pause_en", src_en, 0);
    check_output("pause_note", note_out, 0);
    check_output("pause_led", led_out, 0);
    btn_pause = 1'b0;
    tick(10);
    btn_pause = 1'b1;
    tick(8);
    check_output("resume_paused", paused, 0);
    check_output("resume_en", src_en, 3'b010);
    check_output("resume_restart", src_restart, 0);
    btn_pause = 1'b0;
    auto_note = 4'hF;
    tick(1);
    check_output("end_note", note_out, 0);
    check_output("end_led", led_out, 0);
    check_output("end_oct", octave_out, 1);
    auto_note = 4'd5;
    tick(1);
    check_output("after_end_note", note_out, 5);
    tick(8);

    // next and pause together from AUTO, then prev retargets mid-gap
    btn_next = 1'b1; btn_pause = 1'b1;
    tick(5);
    btn_prev = 1'b1;
    tick(3);
    check_output("coinc_mode", mode_out, 2'b10);
    check_output("coinc_paused", paused, 0);
    check_output("coinc_en", src_en, 0);
    btn_next = 1'b0; btn_pause = 1'b0;
    tick(5);
    check_output("retarget_mode", mode_out, 2'b01);
    btn_prev = 1'b0;
    tick(7);
    check_output("retarget_restart_early", src_restart, 0);
    check_output("retarget_mute_note", note_out, 0);
    tick(1);
    check_output("retarget_restart", src_restart, 3'b010);
    check_output("retarget_en", src_en, 3'b010);
    tick(1);
    check_output("retarget_note", note_out, 5);

    btn_next = 1'b1; btn_prev = 1'b1;
    tick(8);
    check_output("cancel_mode", mode_out, 2'b01);
    check_output("cancel_en", src_en, 3'b010);
    tick(2);
    check_output("cancel_note", note_out, 5);
    btn_next = 1'b0; btn_prev = 1'b0;
    tick(10);

    btn_next = 1'b1;
    tick(8);
    check_output("gap_mode", mode_out, 2'b10);
    btn_next = 1'b0;
    tick(3);
    check_output("gap_oct_hold", octave_out, 1);
    check_output("gap_note", note_out, 0);
    reset = 1'b0;
    #1;
    check_output("midgap_mode", mode_out, 0);
    check_output("midgap_en", src_en, 3'b001);
    check_output("midgap_oct", octave_out, 0);
    check_output("midgap_restart", src_restart, 0);
    check_output("midgap_paused", paused, 0);
    tick(2);
    reset = 1'b1;
    tick(1);
    check_output("post_reset_note", note_out, 3);
    check_output("post_reset_restart", src_restart, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
